// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared op and state encodings for the serial shift unit
package shift_sequencer_pkg;

  // Shift operation encodings, shared with the ALU decoder.
  // 2'b10 is reserved and behaves as a logical right shift.
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_RSV = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  // Sequencer state encodings.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // Default datapath width and matching shift-amount width.
  localparam int unsigned N_DEFAULT   = 32;
  localparam int unsigned SHW_DEFAULT = 5;

endpackage

// File: rtl/shift_sequencer_step.sv
// rtl/shift_sequencer_step.sv - combinational single-bit shift step
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] w_i,
  input  op_e          op_i,
  output logic [N-1:0] w_o
);

  // One-bit shift; SRA replicates the current MSB, which is the original sign bit.
  always_comb begin
    w_o = {1'b0, w_i[N-1:1]};
    case (op_i)
      OP_SLL:  w_o = {w_i[N-2:0], 1'b0};
      OP_SRA:  w_o = {w_i[N-1], w_i[N-1:1]};
      default: w_o = {1'b0, w_i[N-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle RV32 shift unit, one bit per cycle
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   a,
  input  logic [SHW-1:0] shamt,
  input  logic           flush,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   result
);

  state_e         state_q, state_d;
  logic [SHW-1:0] count_q, count_d;
  logic [N-1:0]   work_q, work_d;
  op_e            op_q, op_d;
  logic [N-1:0]   result_q, result_d;
  logic           done_q, done_d;
  logic [N-1:0]   step_w;

  shift_step #(.N(N)) u_step (
    .w_i  (work_q),
    .op_i (op_q),
    .w_o  (step_w)
  );

  // Next-state logic: accept in IDLE, shift until the count runs out, report in DONE.
  // The result is captured on entry to DONE so it is stable while done is high.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    work_d   = work_q;
    op_d     = op_q;
    result_d = result_q;
    done_d   = 1'b0;

    if (flush) begin
      // Kill wins over a same-cycle start; operands and result stay untouched.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            work_d  = a;
            op_d    = op_e'(op);
            count_d = shamt;
            if (shamt == '0) begin
              state_d  = S_DONE;
              result_d = a;
              done_d   = 1'b1;
            end else begin
              state_d = S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          // count is at least 1 here, so the decrement never wraps.
          work_d  = step_w;
          count_d = count_q - SHW'(1);
          if (count_q == SHW'(1)) begin
            state_d  = S_DONE;
            result_d = step_w;
            done_d   = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counter, operand and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      work_q   <= '0;
      op_q     <= OP_SLL;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      work_q   <= work_d;
      op_q     <= op_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done   = done_q;
  assign result = result_q;

endmodule
